// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the PC, runs the instruction-memory read handshake and buffers one tagged instruction for decode
module pc_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               wrap_flag
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n, addr_n, ipc_n;
    logic [INSTR_W-1:0] data_n;
    logic               req_n, valid_n, wrap_n, buf_free;

    assign buf_free = !instr_valid || instr_ready;
    assign pc_out   = pc;

    // register state and every output; reset abandons any outstanding fetch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
            wrap_flag   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instr_valid <= valid_n;
            instr_data  <= data_n;
            instr_pc    <= ipc_n;
            wrap_flag   <= wrap_n;
        end
    end

    // next state: a redirect always wins over capture and consume; an in-flight read is drained in DISCARD
    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = imem_req;
        addr_n  = imem_addr;
        valid_n = instr_valid;
        data_n  = instr_data;
        ipc_n   = instr_pc;
        wrap_n  = wrap_flag;
        if (redirect_valid) begin
            pc_n    = redirect_addr;
            valid_n = 1'b0;
            if (state != IDLE && imem_ack) begin
                state_n = IDLE;
                req_n   = 1'b0;
            end else if (state == FETCH) begin
                state_n = DISCARD;
            end
        end else begin
            if (instr_valid && instr_ready)
                valid_n = 1'b0;
            case (state)
                IDLE: begin
                    if (enable && buf_free) begin
                        state_n = FETCH;
                        req_n   = 1'b1;
                        addr_n  = pc;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        valid_n = 1'b1;
                        data_n  = imem_rdata;
                        ipc_n   = imem_addr;
                        pc_n    = imem_addr + 1'b1;
                        wrap_n  = wrap_flag || (&imem_addr);
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed, cycle-exact checks of fetch, backpressure, redirect, wrap and async reset
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n, enable, redirect_valid, instr_ready;
    logic [7:0]  redirect_addr;
    logic        imem_req, imem_ack, instr_valid, wrap_flag;
    logic [7:0]  imem_addr, instr_pc, pc_out;
    logic [15:0] imem_rdata, instr_data;
    int          checks = 0, errors = 0;
    int          mem_lat = 0, mem_cnt = 0;

    pc_fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .pc_out(pc_out), .wrap_flag(wrap_flag)
    );

    always #5 clk = ~clk;

    // memory: acks after mem_lat extra request cycles, returns {8'h00, addr}
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                imem_ack   = (mem_cnt == mem_lat);
                imem_rdata = {8'h00, imem_addr};
                mem_cnt    = mem_cnt + 1;
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        tick(2);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_data", instr_data, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_pc", pc_out, 0);
        check("rst_wrap", wrap_flag, 0);

        // sequential fetch, one instruction every 2 cycles
        reset_n = 1'b1; enable = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("seq_req", imem_req, 1);
            check("seq_addr", imem_addr, i);
            check("seq_valid_lo", instr_valid, 0);
            tick(1);
            check("seq_valid", instr_valid, 1);
            check("seq_ipc", instr_pc, i);
            check("seq_data", instr_data, i);
            check("seq_pc", pc_out, i + 1);
            check("seq_req_lo", imem_req, 0);
        end
        enable = 1'b0;
        tick(1);
        check("seq_end_valid", instr_valid, 0);
        check("seq_end_req", imem_req, 0);
        check("seq_end_pc", pc_out, 4);

        // backpressure: redirect to 0, then hold instr_ready low after the capture
        redirect_valid = 1'b1; redirect_addr = 8'h00; instr_ready = 1'b0; enable = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        check("bp_pc", pc_out, 0);
        check("bp_req0", imem_req, 0);
        tick(1);
        check("bp_req1", imem_req, 1);
        check("bp_addr", imem_addr, 0);
        tick(1);
        check("bp_valid", instr_valid, 1);
        check("bp_data", instr_data, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("bp_hold_req", imem_req, 0);
            check("bp_hold_valid", instr_valid, 1);
            check("bp_hold_data", instr_data, 16'h0000);
        end
        instr_ready = 1'b1;
        tick(1);
        check("bp_rel_req", imem_req, 1);
        check("bp_rel_addr", imem_addr, 1);
        check("bp_rel_valid", instr_valid, 0);
        tick(1);
        check("bp_rel_ipc", instr_pc, 1);
        check("bp_rel_v", instr_valid, 1);
        enable = 1'b0;
        tick(1);
        check("bp_end_valid", instr_valid, 0);
        check("bp_end_pc", pc_out, 2);

        // redirect while a slow fetch at 0x05 is outstanding
        redirect_valid = 1'b1; redirect_addr = 8'h05;
        tick(1);
        redirect_valid = 1'b0; enable = 1'b1; mem_lat = 3;
        tick(1);
        check("rd_req", imem_req, 1);
        check("rd_addr", imem_addr, 8'h05);
        redirect_valid = 1'b1; redirect_addr = 8'h40;
        tick(1);
        redirect_valid = 1'b0;
        check("rd_pc", pc_out, 8'h40);
        for (int i = 0; i < 3; i++) begin
            check("rd_hold_req", imem_req, 1);
            check("rd_hold_addr", imem_addr, 8'h05);
            tick(1);
        end
        check("rd_drop_req", imem_req, 0);
        check("rd_drop_valid", instr_valid, 0);
        check("rd_drop_pc", pc_out, 8'h40);
        mem_lat = 0;
        tick(1);
        check("rd_new_req", imem_req, 1);
        check("rd_new_addr", imem_addr, 8'h40);
        tick(1);
        check("rd_new_valid", instr_valid, 1);
        check("rd_new_ipc", instr_pc, 8'h40);
        check("rd_new_data", instr_data, 16'h0040);
        enable = 1'b0;
        tick(1);

        // redirect arriving in the same cycle as the ack
        redirect_valid = 1'b1; redirect_addr = 8'h07;
        tick(1);
        redirect_valid = 1'b0; enable = 1'b1;
        tick(1);
        check("col_addr", imem_addr, 8'h07);
        redirect_valid = 1'b1; redirect_addr = 8'h10;
        tick(1);
        redirect_valid = 1'b0;
        check("col_valid", instr_valid, 0);
        check("col_pc", pc_out, 8'h10);
        check("col_req", imem_req, 0);
        check("col_ipc", instr_pc, 8'h40);
        tick(1);
        check("col_next_addr", imem_addr, 8'h10);
        tick(1);
        check("col_next_ipc", instr_pc, 8'h10);
        enable = 1'b0;
        tick(1);

        // wrap from 0xFF to 0x00
        redirect_valid = 1'b1; redirect_addr = 8'hFE;
        tick(1);
        redirect_valid = 1'b0; enable = 1'b1;
        tick(2);
        check("wr_ipc0", instr_pc, 8'hFE);
        check("wr_flag0", wrap_flag, 0);
        tick(2);
        check("wr_ipc1", instr_pc, 8'hFF);
        check("wr_pc", pc_out, 8'h00);
        check("wr_flag1", wrap_flag, 1);
        tick(2);
        check("wr_ipc2", instr_pc, 8'h00);
        check("wr_flag2", wrap_flag, 1);
        mem_lat = 5;

        // asynchronous reset in the middle of a fetch
        tick(1);
        check("ar_req", imem_req, 1);
        check("ar_addr", imem_addr, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        check("ar_req0", imem_req, 0);
        check("ar_valid0", instr_valid, 0);
        check("ar_pc0", pc_out, 0);
        check("ar_wrap0", wrap_flag, 0);
        @(negedge clk);
        reset_n = 1'b1; mem_lat = 0;
        tick(1);
        check("ar_first_req", imem_req, 1);
        check("ar_first_addr", imem_addr, 8'h00);
        tick(1);
        check("ar_first_ipc", instr_pc, 8'h00);
        check("ar_first_valid", instr_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC path: holds the architectural 8-bit program counter.
- Accepts the computed overwrite address (jump/branch/reset target) as a redirect.
- Runs the instruction-memory read handshake and presents one fetched instruction, tagged with its PC, to decode.
- Sits between the PC datapath, instruction memory and the decode stage.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 16, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new fetch is started; an outstanding fetch still completes.
- redirect_valid  input  1  single-cycle pulse: load redirect_addr into the PC and flush.
- redirect_addr  input  ADDR_W  new PC target (overwrite data from the PC datapath).
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  ADDR_W  read address; stable while imem_req is high.
- imem_ack  input  1  read complete; imem_rdata is valid this cycle.
- imem_rdata  input  INSTR_W  read data.
- instr_valid  output  1  instr_data and instr_pc are valid.
- instr_ready  input  1  decode accepts the instruction when instr_valid && instr_ready.
- instr_data  output  INSTR_W  buffered instruction.
- instr_pc  output  ADDR_W  address the buffered instruction was fetched from.
- pc_out  output  ADDR_W  current PC, i.e. the next address to fetch.
- wrap_flag  output  1  sticky; set when the PC increments from 0xFF to 0x00.

Behaviour:
- Reset (asynchronous, while reset_n is low):
  - pc = 0, state = IDLE.
  - imem_req = 0, imem_addr = 0.
  - instr_valid = 0, instr_data = 0, instr_pc = 0, wrap_flag = 0.
- Reset mid-fetch abandons the fetch. Memory must tolerate a request being dropped by reset.
- All outputs are registered.
- The instruction buffer holds one entry. It is "free" when instr_valid == 0, or when instr_valid && instr_ready in the current cycle.
- State IDLE:
  - If enable && buffer free && !redirect_valid: next cycle go to FETCH, with imem_req = 1 and imem_addr = pc.
- State FETCH:
  - imem_req and imem_addr are held constant until imem_ack is sampled high. imem_ack is legal on the first req cycle.
  - On imem_ack && !redirect_valid:
    - instr_data <= imem_rdata, instr_pc <= imem_addr, instr_valid <= 1.
    - pc <= imem_addr + 1, modulo 2^ADDR_W.
    - If imem_addr == 0xFF, set wrap_flag.
    - imem_req <= 0; go to IDLE.
- Throughput: at most one instruction every 2 cycles with a zero-wait memory.
- Consume: when instr_valid && instr_ready and no new capture occurs that cycle, instr_valid <= 0.
- Redirect (any state, redirect_valid high on a clock edge):
  - pc <= redirect_addr.
  - instr_valid <= 0; the buffered instruction is discarded, even if instr_ready is high the same cycle.
  - From IDLE: stay in IDLE. The next fetch uses the new PC.
  - From FETCH without ack: go to DISCARD. imem_req stays high with the old address.
  - From FETCH with ack in the same cycle: redirect wins. The data is dropped and the PC is not incremented; go to IDLE.
- State DISCARD:
  - Keep imem_req high until imem_ack, then drop imem_rdata, set imem_req <= 0 and go to IDLE.
  - A further redirect in DISCARD overwrites pc again and stays in DISCARD.
- Deasserting enable during FETCH or DISCARD does not abort the transfer.
- pc_out always reflects the pc register.
- wrap_flag is cleared only by reset.

Test Plan:
- Sequential fetch: reset, enable = 1, instr_ready = 1, zero-wait memory returning {8'h00, addr} -> instr_valid pulses carry instr_pc 0, 1, 2, 3; instr_data 0x0000, 0x0001, …; pc_out ends at 4; imem_req never rises while the buffer is full.
- Backpressure: instr_ready = 0 after the first capture (pc 0x00) -> no further imem_req; instr_data held at 0x0000; raise instr_ready -> fetch of 0x01 starts on the next cycle.
- Redirect with outstanding fetch: FETCH at 0x05 with ack delayed 3 cycles; redirect_addr = 0x40 in cycle 1 -> req held at 0x05 until ack, data dropped, next request at 0x40, first valid instr_pc = 0x40.
- Redirect colliding with ack: imem_ack and redirect_valid (0x10) in the same cycle at addr 0x07 -> instr_valid stays 0, pc_out = 0x10, next imem_addr = 0x10.
- Wrap: redirect to 0xFE, fetch twice -> instr_pc 0xFE then 0xFF; pc_out = 0x00; wrap_flag = 1 and stays 1 after further fetches.
- Async reset mid-FETCH: assert reset_n = 0 between clock edges -> imem_req, instr_valid and pc_out go to 0 immediately; after release the first request is at 0x00.
